unidad_control: RTL and testbench
=================================

// Module: unidad_control
// PURPOSE
//  Microprogrammed sequencer that sits directly upstream of the processing unit.
//  - Drives its 16-bit control word {A[15:13],B[12:10],D[9:7],ALU[6:3],SH[2:0]}.
//  - Consumes its registered stateBits {V,N,Z,C} to take conditional branches.
//  - Holds a writable microprogram store, runs from address 0 on start, signals done on a halt microinstruction.
// PARAMETERS
//  ADDR_W  5   microprogram address width (2**ADDR_W words)
//  CW_W    16  control-word width; fixed to match the datapath
//  MI_W    CW_W+3+ADDR_W (24)  microinstruction width: {cw[CW_W-1:0], cond[2:0], target[ADDR_W-1:0]}
// PORTS
//  clk        in   1       system clock, all state updates on posedge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       level; sampled at posedge in IDLE or DONE
//  flags      in   4       stateBits from the datapath, {V,N,Z,C}
//  prog_we    in   1       microprogram write enable (honoured in IDLE/DONE only)
//  prog_addr  in   ADDR_W  microprogram write address
//  prog_data  in   MI_W    microprogram write data
//  ctrl_word  out  CW_W    control word to the datapath
//  upc        out  ADDR_W  current micro-PC
//  busy       out  1       1 while in RUN
//  done       out  1       1 while in DONE
// BEHAVIOUR
//  Reset values
//  - state=IDLE, upc=0, busy=0, done=0, ctrl_word=0.
//  - Store contents are NOT reset.
//  Store
//  - 2**ADDR_W x MI_W array; synchronous write, asynchronous read of word mi=store[upc].
//  Outputs
//  - ctrl_word = mi.cw only when state==RUN and mi.cond!=3'b111; otherwise 0.
//  - 0 means D=0, so the datapath does no register write (NOP).
//  FSM
//  - IDLE: start=1 -> RUN, upc<=0.
//  - RUN: next upc chosen by mi.cond (see below); cond=111 -> DONE, upc held.
//  - DONE: done=1. start=1 -> RUN, upc<=0 (restart, done drops the same edge).
//  cond field
//  - 000: upc+1.
//  - 001: target, unconditional.
//  - 010: target if Z, else upc+1.
//  - 011: target if N, else upc+1.
//  - 100: target if C, else upc+1.
//  - 101: target if V, else upc+1.
//  - 110: target if !Z, else upc+1.
//  - 111: halt.
//  Flag timing
//  - flags are registered one cycle after the ALU op in the datapath.
//  - A branch at upc=k tests the flags produced by the word issued at upc=k-1.
//  - Microcode needing the flags of word k inserts nothing extra: word k+1 branches on them.
//  Arithmetic
//  - upc+1 is modulo 2**ADDR_W: 31 -> 0 with ADDR_W=5.
//  - Jump target is used as-is.
//  Simultaneous and boundary events
//  - prog_we while RUN is ignored (store unchanged).
//  - start while RUN is ignored.
//  - prog_we and start on the same edge in IDLE: write occurs and RUN begins.
//  - A write to address 0 on that edge is visible at the first RUN cycle.
//  - reset mid-RUN: IDLE immediately (async); ctrl_word=0 with no further edge.
//  - X on flags while cond is not a branch must not affect upc.
// TESTING
//  - Reset mid-run: prog 0:{cw=16'h2408,cond=000}, 1:{cond=001,tgt=1} (loop); start; reset at cycle 5
//    -> ctrl_word=0, upc=0, busy=0 asynchronously; store still holds 16'h2408 at address 0.
//  - Linear run: prog 0..2 cond=000 with cw 16'h0088/16'h0510/16'h2408, 3 cond=111; pulse start
//    -> ctrl_word sequence 0088,0510,2408,0000; done=1 from cycle 4; busy high for 4 cycles.
//  - Branch Z: word 5 cond=010 tgt=9; flags=4'b0010 -> upc 5->9; repeat with flags=0 -> 5->6.
//    Repeat for N (4'b0100), C (4'b0001), V (4'b1000) and !Z.
//  - Wrap: word 31 cond=000, reached via jump from 0 -> next upc=0.
//  - Program lockout: prog_we to addr 2 while busy -> readback via a later run shows the old word.
//    Start during RUN leaves upc path unchanged.
//  - Restart from DONE: start=1 in DONE -> done=0 and upc=0 on the same edge, run repeats the identical ctrl_word trace.

Source files
------------

// File: rtl/unidad_control.sv
`default_nettype none
// unidad_control: microprogrammed sequencer with a writable store. It issues control words
// to the datapath and branches on the datapath's registered {V,N,Z,C} flags.
module unidad_control #(
  parameter int ADDR_W = 5,
  parameter int CW_W   = 16,
  parameter int MI_W   = CW_W + 3 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        flags,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [MI_W-1:0]   prog_data,
  output logic [CW_W-1:0]   ctrl_word,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] COND_NEXT = 3'b000;
  localparam logic [2:0] COND_JMP  = 3'b001;
  localparam logic [2:0] COND_Z    = 3'b010;
  localparam logic [2:0] COND_N    = 3'b011;
  localparam logic [2:0] COND_C    = 3'b100;
  localparam logic [2:0] COND_V    = 3'b101;
  localparam logic [2:0] COND_NZ   = 3'b110;
  localparam logic [2:0] COND_HALT = 3'b111;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] upc_next;
  logic [ADDR_W-1:0] upc_inc;

  logic [MI_W-1:0]   store [2**ADDR_W];
  logic [MI_W-1:0]   mi;
  logic [CW_W-1:0]   mi_cw;
  logic [2:0]        mi_cond;
  logic [ADDR_W-1:0] mi_target;
  logic              take;

  assign mi        = store[upc];
  assign mi_cw     = mi[MI_W-1 -: CW_W];
  assign mi_cond   = mi[ADDR_W +: 3];
  assign mi_target = mi[ADDR_W-1:0];
  assign upc_inc   = upc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Store has no reset; writes are locked out while the microprogram is executing.
  always_ff @(posedge clk) begin
    if (prog_we && (state != RUN)) begin
      store[prog_addr] <= prog_data;
    end
  end

  // flags = {V,N,Z,C}; only branch conditions look at them
  always_comb begin
    take = 1'b0;
    case (mi_cond)
      COND_JMP: take = 1'b1;
      COND_Z:   take = flags[1];
      COND_N:   take = flags[2];
      COND_C:   take = flags[0];
      COND_V:   take = flags[3];
      COND_NZ:  take = ~flags[1];
      default:  take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      upc   <= '0;
    end else begin
      state <= state_next;
      upc   <= upc_next;
    end
  end

  always_comb begin
    state_next = state;
    upc_next   = upc;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          upc_next   = '0;
        end
      end
      RUN: begin
        if (mi_cond == COND_HALT) begin
          state_next = DONE;
        end else if (take) begin
          upc_next = mi_target;
        end else begin
          upc_next = upc_inc;
        end
      end
      default: begin
        state_next = IDLE;
        upc_next   = '0;
      end
    endcase
  end

  // A zero word has D=0, so the datapath sees a NOP outside active microinstructions.
  assign ctrl_word = ((state == RUN) && (mi_cond != COND_HALT)) ? mi_cw : '0;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  logic unused_cond;
  assign unused_cond = (mi_cond == COND_NEXT);

endmodule
`default_nettype wire

// File: tb/tb_unidad_control.sv
`default_nettype none
// tb_unidad_control: randomized scoreboard bench; a microprogram-walking reference model
// predicts the per-cycle {ctrl_word, upc} trace, and a monitor compares it while busy.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  flags = 4'h0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = 5'd0;
  logic [23:0] prog_data = 24'd0;
  logic [15:0] ctrl_word;
  logic [4:0]  upc;
  logic        busy;
  logic        done;

  int total = 0;
  int passed = 0;

  logic [23:0] model_mem [32];
  logic [20:0] exp_q [$];

  unidad_control dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flags     (flags),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ctrl_word (ctrl_word),
    .upc       (upc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [23:0] mk(input logic [15:0] cw, input logic [2:0] cond,
                                     input logic [4:0] tgt);
    return {cw, cond, tgt};
  endfunction

  // f = {V,N,Z,C}
  function automatic bit branch_taken(input logic [2:0] cond, input logic [3:0] f);
    case (cond)
      3'd1:    return 1'b1;
      3'd2:    return f[1];
      3'd3:    return f[2];
      3'd4:    return f[0];
      3'd5:    return f[3];
      3'd6:    return !f[1];
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every busy cycle must match the next predicted trace entry.
  always @(negedge clk) begin
    if (busy) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL trace_extra: got %h expected no busy cycle", {ctrl_word, upc});
      end else begin
        check("trace", {11'd0, ctrl_word, upc}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic write_word(input int a, input logic [23:0] d);
    prog_we   = 1'b1;
    prog_addr = 5'(a);
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Entered and left at posedge+1. Runs until halt or for 'limit' cycles, then aborts via reset.
  task automatic do_run(input int limit, input bit use_fixed, input logic [3:0] fixed_flags,
                        input bit allow_w0);
    logic [3:0]  fl [64];
    logic [23:0] mi;
    logic [23:0] w0;
    int          pc;
    int          n;
    int          hpc;
    bit          halted;

    if (allow_w0 && $urandom_range(0, 2) == 0) begin
      w0 = mk(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
      prog_we = 1'b1; prog_addr = 5'd0; prog_data = w0;
      model_mem[0] = w0;
    end
    pc = 0; n = 0; halted = 0; hpc = 0;
    while (n < limit && !halted) begin
      mi = model_mem[pc];
      fl[n] = use_fixed ? fixed_flags : 4'($urandom);
      if (mi[7:5] == 3'b111) begin
        exp_q.push_back({16'h0000, 5'(pc)});
        halted = 1; hpc = pc;
      end else begin
        exp_q.push_back({mi[23:8], 5'(pc)});
        pc = branch_taken(mi[7:5], fl[n]) ? int'(mi[4:0]) : (pc + 1) % 32;
      end
      n++;
    end

    start = 1'b1;
    @(posedge clk); #1;
    check("run_entry", {30'd0, busy, done}, 32'b10);
    for (int i = 0; i < n; i++) begin
      flags     = fl[i];
      start     = 1'($urandom);
      prog_we   = 1'($urandom);
      prog_addr = 5'($urandom);
      prog_data = 24'($urandom);
      if (i == n - 1 && !halted) begin
        #6;
        reset = 1'b1; prog_we = 1'b0; start = 1'b0;
        #1;
        check("abort_reset", {ctrl_word, upc, busy, done}, 32'd0);
        check("abort_queue", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; prog_we = 1'b0;
    @(negedge clk);
    check("halt_state", {ctrl_word, upc, busy, done}, {16'h0000, 5'(hpc), 2'b01});
    check("halt_queue", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset_vals", {ctrl_word, upc, busy, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-run on a looping program; store must keep word 0.
    write_word(0, mk(16'h2408, 3'b000, 5'd0));
    write_word(1, mk(16'h0000, 3'b001, 5'd1));
    do_run(5, 0, 4'h0, 0);
    write_word(1, mk(16'h0000, 3'b111, 5'd0));
    do_run(8, 0, 4'h0, 0);

    // Linear run, then restart from DONE with lockout writes to the store during RUN.
    write_word(0, mk(16'h0088, 3'b000, 5'd0));
    write_word(1, mk(16'h0510, 3'b000, 5'd0));
    write_word(2, mk(16'h2408, 3'b000, 5'd0));
    write_word(3, mk(16'h0000, 3'b111, 5'd0));
    do_run(10, 0, 4'h0, 0);
    do_run(10, 0, 4'h0, 0);

    // Conditional branches, taken and not taken.
    write_word(0, mk(16'h1234, 3'b001, 5'd5));
    write_word(6, mk(16'h0000, 3'b111, 5'd0));
    write_word(9, mk(16'h0000, 3'b111, 5'd0));
    for (int c = 2; c <= 6; c++) begin
      logic [3:0] hit;
      case (c)
        2: hit = 4'b0010;
        3: hit = 4'b0100;
        4: hit = 4'b0001;
        5: hit = 4'b1000;
        default: hit = 4'b0000;
      endcase
      write_word(5, mk(16'h4321, 3'(c), 5'd9));
      do_run(10, 1, hit, 0);
      do_run(10, 1, (c == 6) ? 4'b0010 : 4'b0000, 0);
    end

    // Wrap 31 -> 0.
    write_word(0, mk(16'h1111, 3'b001, 5'd31));
    write_word(31, mk(16'h2222, 3'b000, 5'd0));
    do_run(6, 0, 4'h0, 0);

    // Random microprograms with random flags, start/prog_we noise and start-edge writes.
    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < 32; a++) begin
        write_word(a, mk(16'($urandom),
                         ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 6)),
                         5'($urandom)));
      end
      do_run(40, 0, 4'h0, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
